// File: rtl/hex_display_ctrl_pkg.sv
// hex_display_ctrl_pkg
// Shared definitions for the hex display controller: display modes, the
// blank segment byte and the helper that folds the reserved mode onto STATIC.
package hex_display_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // Active-low segments plus DP, all off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // The reserved encoding behaves exactly like STATIC.
  function automatic mode_e eff_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_STATIC : mode_e'(m);
  endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// hex_display_ctrl_if
// Load channel into the display controller.
//   load_valid : data_in/dp_in valid (master -> slave)
//   load_ready : controller can accept a load (slave -> master)
//   data_in    : 4*NUM_DIGITS packed nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp_in      : NUM_DIGITS decimal-point requests, active-high
interface hex_display_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 6
);
  logic                      load_valid;
  logic                      load_ready;
  logic [4*NUM_DIGITS-1:0]   data_in;
  logic [NUM_DIGITS-1:0]     dp_in;

  modport master (output load_valid, output data_in, output dp_in, input load_ready);
  modport slave  (input load_valid, input data_in, input dp_in, output load_ready);
endinterface

// File: rtl/hex_display_ctrl_dec.sv
// seven_seg_decoder_bool
// Hex nibble to active-low 7-segment pattern.
//   nibble : 4-bit value 0..F
//   seg    : segments {g,f,e,d,c,b,a}, bit0 = a, 0 = lit
module seven_seg_decoder_bool (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
// Registered driver for NUM_DIGITS active-low 7-seg+DP displays. Latches a
// nibble vector through the load channel and renders it with digit enable,
// decimal points, leading-zero blanking and STATIC / BLINK / SCROLL modes.
//   clk, reset_n : single clock, asynchronous active-low reset
//   load         : load channel (valid/ready, data_in, dp_in)
//   mode         : 0 STATIC, 1 BLINK, 2 SCROLL, 3 = STATIC
//   digit_en     : 1 = digit shown, 0 = forced blank
//   blink_mask   : digits blanked during the BLINK off phase
//   lzb_en       : leading-zero blanking enable (ignored in SCROLL)
//   hex_out      : byte i -> HEX i, bit7 = DP, active-low, 8'hFF = blank
//   scroll_wrap  : one-cycle pulse after scroll position wraps to 0
module hex_display_ctrl
  import hex_display_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned TICK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hex_display_ctrl_if.slave       load,
  input  logic [1:0]              mode,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lzb_en,
  output logic [8*NUM_DIGITS-1:0] hex_out,
  output logic                    scroll_wrap
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam int unsigned POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]          tick_cnt;
  logic                      tick;
  logic [1:0]                mode_prev;
  logic                      mode_change;
  mode_e                     cur_mode;
  logic [4*NUM_DIGITS-1:0]   shadow_data;
  logic [NUM_DIGITS-1:0]     shadow_dp;
  logic                      blink_phase, blink_next;
  logic [POS_W-1:0]          scroll_pos, pos_next;
  logic                      wrap_next;
  logic                      accept;
  logic [3:0]                rot_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     rot_dp;
  logic [6:0]                seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     lzb_blank;
  logic [8*NUM_DIGITS-1:0]   hex_next;

  assign tick        = (tick_cnt == CNT_MAX);
  assign cur_mode    = eff_mode(mode);
  assign mode_change = (mode != mode_prev);
  // Hold off new data while a scroll pass is in progress so a pass never tears.
  assign load.load_ready = !((cur_mode == MODE_SCROLL) && (scroll_pos != '0));
  assign accept      = load.load_valid && load.load_ready;

  // Blink/scroll state: a mode change clears both; outside their own mode they sit at 0.
  always_comb begin
    blink_next = 1'b0;
    pos_next   = '0;
    wrap_next  = 1'b0;
    if (!mode_change) begin
      if (cur_mode == MODE_BLINK)
        blink_next = tick ? ~blink_phase : blink_phase;
      if (cur_mode == MODE_SCROLL) begin
        pos_next = scroll_pos;
        if (tick) begin
          if (scroll_pos == POS_MAX) begin
            pos_next  = '0;
            wrap_next = 1'b1;
          end else begin
            pos_next = scroll_pos + 1'b1;
          end
        end
      end
    end
  end

  // Digit i shows nibble (i + scroll_pos) mod N; the DP travels with its nibble.
  always_comb begin
    int unsigned idx;
    rot_nib = '{default: '0};
    rot_dp  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      idx = i + 32'(scroll_pos);
      if (idx >= NUM_DIGITS) idx = idx - NUM_DIGITS;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
        if (j == idx) begin
          rot_nib[i] = shadow_data[j*4 +: 4];
          rot_dp[i]  = shadow_dp[j];
        end
      end
    end
  end

  // Scan from the top digit down; blank zeros until a nonzero nibble or a DP is seen.
  always_comb begin
    logic keep;
    keep      = 1'b0;
    lzb_blank = '0;
    for (int unsigned k = 0; k + 1 < NUM_DIGITS; k++) begin
      if ((shadow_data[(NUM_DIGITS-1-k)*4 +: 4] != 4'd0) || shadow_dp[NUM_DIGITS-1-k])
        keep = 1'b1;
      lzb_blank[NUM_DIGITS-1-k] = ~keep;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seven_seg_decoder_bool u_dec (
      .nibble (rot_nib[g]),
      .seg    (seg[g])
    );
  end

  always_comb begin
    logic blank;
    hex_next = '1;
    blank    = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      blank = 1'b0;
      if (!digit_en[i])
        blank = 1'b1;
      else if ((cur_mode == MODE_BLINK) && blink_phase && blink_mask[i])
        blank = 1'b1;
      else if ((cur_mode != MODE_SCROLL) && lzb_en && lzb_blank[i])
        blank = 1'b1;
      hex_next[i*8 +: 8] = blank ? SEG_BLANK : {~rot_dp[i], seg[i]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt    <= '0;
      mode_prev   <= 2'd0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      blink_phase <= 1'b0;
      scroll_pos  <= '0;
      scroll_wrap <= 1'b0;
      hex_out     <= '1;
    end else begin
      tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
      mode_prev   <= mode;
      if (accept) begin
        shadow_data <= load.data_in;
        shadow_dp   <= load.dp_in;
      end
      blink_phase <= blink_next;
      scroll_pos  <= pos_next;
      scroll_wrap <= wrap_next;
      hex_out     <= hex_next;
    end
  end

endmodule
